// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: holds PC, pipelines PC+1 into the decode
// (PC_1) and execute (PC_2) stages, and resolves branch/jump redirects from EX.
module pc_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter bit               ANNUL    = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             STALL,
  input  logic [1:0]       BS,
  input  logic             PS,
  input  logic             Z,
  input  logic [WIDTH-1:0] BrA,
  input  logic [WIDTH-1:0] RAA,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_1,
  output logic [WIDTH-1:0] PC_2,
  output logic             V_1,
  output logic             V_2,
  output logic             TAKEN
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_next;
  logic             cond_taken;
  logic             kill;

  // V_1/V_2 qualify the decode/execute slots: a slot with V=0 is a bubble and
  // its BS/PS/Z/BrA/RAA are ignored, so it can never redirect the fetch.
  always_comb begin
    pc_inc     = PC + ONE;
    cond_taken = 1'b0;
    target     = BrA;
    case (BS)
      2'b00: cond_taken = 1'b0;
      2'b01: cond_taken = Z ^ PS;
      2'b10: begin
        cond_taken = 1'b1;
        target     = RAA;
      end
      2'b11: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
    TAKEN   = V_2 & ~STALL & cond_taken;
    kill    = ANNUL & TAKEN;
    pc_next = TAKEN ? target : pc_inc;
  end

  // A stall freezes every stage, so a pending transfer is simply re-evaluated
  // once the upstream stops stalling.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PC   <= RESET_PC;
      PC_1 <= '0;
      PC_2 <= '0;
      V_1  <= 1'b0;
      V_2  <= 1'b0;
    end else if (!STALL) begin
      PC   <= pc_next;
      PC_1 <= pc_inc;
      PC_2 <= PC_1;
      V_1  <= ~kill;
      V_2  <= V_1 & ~kill;
    end
  end

endmodule
